riscv_tag_prop_ctrl: RTL and testbench

Tag-propagation control stage for the DIFT extension of RI5CY. It holds the software-programmable tag propagation policy (one 2-bit mode per instruction class) and, for each instruction leaving ID, looks up that class's mode. It registers the mode into the ID/EX pipeline register that directly drives `operator_i` of the tag ALU in EX. CSR writes to the policy are sequenced so that no instruction is ever issued with a stale or half-updated policy.

---
 rtl/riscv_tag_prop_ctrl_pkg.sv | 40 ++++
 rtl/riscv_tag_policy_regs.sv | 53 +++++
 rtl/riscv_tag_prop_ctrl.sv | 80 ++++++++
 tb/tb_riscv_tag_prop_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_tag_prop_ctrl_pkg.sv
// Shared constants and types for the DIFT tag-propagation control stage.
package riscv_tag_prop_ctrl_pkg;

    localparam int unsigned ALU_MODE_WIDTH = 2;
    localparam int unsigned CLASS_WIDTH    = 3;
    localparam int unsigned POLICY_WIDTH   = 16;
    localparam int unsigned CSR_WIDTH      = 32;

    // Tag ALU operator encoding
    typedef enum logic [ALU_MODE_WIDTH-1:0] {
        ALU_MODE_OLD   = 2'd0,
        ALU_MODE_AND   = 2'd1,
        ALU_MODE_OR    = 2'd2,
        ALU_MODE_CLEAR = 2'd3
    } alu_mode_e;

    // Instruction classes; class k owns policy bits [2k+1:2k]
    typedef enum logic [CLASS_WIDTH-1:0] {
        TAG_CLS_ALU    = 3'd0,
        TAG_CLS_SHIFT  = 3'd1,
        TAG_CLS_CMP    = 3'd2,
        TAG_CLS_LOAD   = 3'd3,
        TAG_CLS_STORE  = 3'd4,
        TAG_CLS_JUMP   = 3'd5,
        TAG_CLS_BRANCH = 3'd6,
        TAG_CLS_CSR    = 3'd7
    } tag_cls_e;

    // Tag propagation register CSR address
    typedef enum logic [11:0] {
        CSR_TPR = 12'h7C0
    } tag_csr_addr_e;

    // Policy update sequencer states
    typedef enum logic {
        PS_IDLE   = 1'b0,
        PS_SETTLE = 1'b1
    } pol_state_e;

endpackage

// File: rtl/riscv_tag_policy_regs.sv
// Architectural and effective tag policy registers with the update sequencer.
module riscv_tag_policy_regs
    import riscv_tag_prop_ctrl_pkg::*;
#(
    parameter int unsigned       POL_W        = POLICY_WIDTH,
    parameter logic [POL_W-1:0]  RESET_POLICY = POL_W'(16'h0EAA)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             csr_we_i,
    input  logic [POL_W-1:0] csr_wdata_i,
    output logic [POL_W-1:0] pol_arch_o,
    output logic [POL_W-1:0] pol_eff_o,
    output logic             settle_o
);

    pol_state_e       state_q;
    logic [POL_W-1:0] pol_arch_q;
    logic [POL_W-1:0] pol_eff_q;

    // CSR write lands in pol_arch; pol_eff follows one quiet cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= PS_IDLE;
            pol_arch_q <= RESET_POLICY;
            pol_eff_q  <= RESET_POLICY;
        end else begin
            case (state_q)
                PS_IDLE: begin
                    if (csr_we_i) begin
                        pol_arch_q <= csr_wdata_i;
                        state_q    <= PS_SETTLE;
                    end
                end
                PS_SETTLE: begin
                    if (csr_we_i) begin
                        pol_arch_q <= csr_wdata_i;
                        state_q    <= PS_SETTLE;
                    end else begin
                        pol_eff_q  <= pol_arch_q;
                        state_q    <= PS_IDLE;
                    end
                end
                default: state_q <= PS_IDLE;
            endcase
        end
    end

    assign pol_arch_o = pol_arch_q;
    assign pol_eff_o  = pol_eff_q;
    assign settle_o   = (state_q == PS_SETTLE);

endmodule

// File: rtl/riscv_tag_prop_ctrl.sv
// Tag-propagation control: policy lookup per ID instruction into the ID/EX tag slot.
module riscv_tag_prop_ctrl
    import riscv_tag_prop_ctrl_pkg::*;
#(
    parameter logic [POLICY_WIDTH-1:0] RESET_POLICY = 16'h0EAA,
    parameter int unsigned             N_CLASSES    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid_i,
    input  logic [CLASS_WIDTH-1:0]    id_class_i,
    output logic                      id_ready_o,
    input  logic                      ex_stall_i,
    input  logic                      ex_flush_i,
    input  logic                      csr_we_i,
    input  logic [CSR_WIDTH-1:0]      csr_wdata_i,
    output logic [CSR_WIDTH-1:0]      csr_rdata_o,
    output logic                      policy_busy_o,
    output logic                      ex_valid_o,
    output logic [ALU_MODE_WIDTH-1:0] ex_alu_mode_o
);

    localparam int unsigned POL_W = N_CLASSES * ALU_MODE_WIDTH;

    logic [POL_W-1:0]          pol_arch;
    logic [POL_W-1:0]          pol_eff;
    logic                      settle;
    logic                      busy_c;
    logic                      ex_valid_d;
    logic [ALU_MODE_WIDTH-1:0] ex_mode_d;
    logic                      ex_valid_q;
    logic [ALU_MODE_WIDTH-1:0] ex_mode_q;
    logic                      unused_wdata;

    riscv_tag_policy_regs #(
        .POL_W        (POL_W),
        .RESET_POLICY (POL_W'(RESET_POLICY))
    ) u_policy_regs (
        .clk         (clk),
        .rst         (rst),
        .csr_we_i    (csr_we_i),
        .csr_wdata_i (csr_wdata_i[POL_W-1:0]),
        .pol_arch_o  (pol_arch),
        .pol_eff_o   (pol_eff),
        .settle_o    (settle)
    );

    assign unused_wdata  = ^csr_wdata_i[CSR_WIDTH-1:POL_W];

    // Busy covers the write cycle itself so nothing issues against a stale pol_eff
    assign busy_c        = csr_we_i | settle;
    assign policy_busy_o = busy_c;
    assign id_ready_o    = !ex_stall_i && !busy_c;
    assign csr_rdata_o   = CSR_WIDTH'(pol_arch);

    // Next slot contents: a bubble while busy, otherwise the class's mode
    always_comb begin
        ex_valid_d = 1'b0;
        ex_mode_d  = ALU_MODE_OLD;
        if (!busy_c && id_valid_i) begin
            ex_valid_d = 1'b1;
            ex_mode_d  = pol_eff[{id_class_i, 1'b0} +: ALU_MODE_WIDTH];
        end
    end

    // ID/EX tag slot: reset/flush, then stall hold, then load
    always_ff @(posedge clk) begin
        if (rst || ex_flush_i) begin
            ex_valid_q <= 1'b0;
            ex_mode_q  <= ALU_MODE_OLD;
        end else if (!ex_stall_i) begin
            ex_valid_q <= ex_valid_d;
            ex_mode_q  <= ex_mode_d;
        end
    end

    assign ex_valid_o    = ex_valid_q;
    assign ex_alu_mode_o = ex_mode_q;

endmodule

// File: tb/tb_riscv_tag_prop_ctrl.sv
// Self-checking bench for riscv_tag_prop_ctrl: directed vectors plus a per-cycle model compare.
module tb_riscv_tag_prop_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid_i;
    logic [2:0]  id_class_i;
    logic        id_ready_o;
    logic        ex_stall_i;
    logic        ex_flush_i;
    logic        csr_we_i;
    logic [31:0] csr_wdata_i;
    logic [31:0] csr_rdata_o;
    logic        policy_busy_o;
    logic        ex_valid_o;
    logic [1:0]  ex_alu_mode_o;

    int n_checks = 0;
    int n_pass   = 0;
    bit started  = 1'b0;

    riscv_tag_prop_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid_i    (id_valid_i),
        .id_class_i    (id_class_i),
        .id_ready_o    (id_ready_o),
        .ex_stall_i    (ex_stall_i),
        .ex_flush_i    (ex_flush_i),
        .csr_we_i      (csr_we_i),
        .csr_wdata_i   (csr_wdata_i),
        .csr_rdata_o   (csr_rdata_o),
        .policy_busy_o (policy_busy_o),
        .ex_valid_o    (ex_valid_o),
        .ex_alu_mode_o (ex_alu_mode_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: the policy an issued instruction sees is the last CSR value
    // once one full cycle has passed without any write.
    int m_arch, m_eff, m_valid, m_mode;
    bit m_wrote_last;

    always @(posedge clk) begin
        if (rst) begin
            m_arch = 16'h0EAA; m_eff = 16'h0EAA;
            m_wrote_last = 1'b0; m_valid = 0; m_mode = 0;
        end else begin
            if (ex_flush_i) begin
                m_valid = 0; m_mode = 0;
            end else if (!ex_stall_i) begin
                m_valid = (id_valid_i && !(csr_we_i || m_wrote_last)) ? 1 : 0;
                m_mode  = m_valid ? ((m_eff >> (2 * int'(id_class_i))) & 3) : 0;
            end
            if (!csr_we_i && m_wrote_last) m_eff = m_arch;
            if (csr_we_i) m_arch = int'(csr_wdata_i & 32'hFFFF);
            m_wrote_last = csr_we_i;
        end
    end

    // Compare outputs against the model mid-cycle
    always @(negedge clk) begin
        if (started) begin
            check("model_valid", 32'(ex_valid_o), 32'(m_valid));
            check("model_mode", 32'(ex_alu_mode_o), 32'(m_mode));
            check("model_rdata", csr_rdata_o, 32'(m_arch));
            check("model_busy", 32'(policy_busy_o), 32'(csr_we_i || m_wrote_last));
            check("model_ready", 32'(id_ready_o), 32'(!ex_stall_i && !(csr_we_i || m_wrote_last)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] c, input logic st,
                         input logic fl, input logic we, input logic [31:0] wd);
        id_valid_i = v; id_class_i = c; ex_stall_i = st;
        ex_flush_i = fl; csr_we_i = we; csr_wdata_i = wd;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        tick(); tick();
        rst = 1'b0;
        started = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        check("rst_valid", 32'(ex_valid_o), 0);
        check("rst_mode", 32'(ex_alu_mode_o), 0);
        check("rst_rdata", csr_rdata_o, 32'h0000_0EAA);
        check("rst_busy", 32'(policy_busy_o), 0);
        check("rst_ready", 32'(id_ready_o), 1);

        // Lookups with the reset policy
        drive(1, 0, 0, 0, 0, 0); tick();
        check("alu_valid", 32'(ex_valid_o), 1);
        check("alu_mode", 32'(ex_alu_mode_o), 2);
        drive(1, 5, 0, 0, 0, 0); tick();
        check("jump_mode", 32'(ex_alu_mode_o), 3);
        drive(1, 6, 0, 0, 0, 0); tick();
        check("branch_mode", 32'(ex_alu_mode_o), 0);
        check("branch_valid", 32'(ex_valid_o), 1);
        drive(0, 5, 0, 0, 0, 0); tick();
        check("novalid_valid", 32'(ex_valid_o), 0);
        check("novalid_mode", 32'(ex_alu_mode_o), 0);

        // Single write; class-6 instruction held through busy
        drive(1, 6, 0, 0, 1, 32'hFFFF_5555);
        check("wr_busy_t", 32'(policy_busy_o), 1);
        check("wr_ready_t", 32'(id_ready_o), 0);
        tick();
        drive(1, 6, 0, 0, 0, 0);
        check("wr_rdata_t1", csr_rdata_o, 32'h0000_5555);
        check("wr_busy_t1", 32'(policy_busy_o), 1);
        check("wr_bubble_t1", 32'(ex_valid_o), 0);
        tick();
        check("wr_busy_t2", 32'(policy_busy_o), 0);
        check("wr_bubble_t2", 32'(ex_valid_o), 0);
        tick();
        check("wr_valid_t3", 32'(ex_valid_o), 1);
        check("wr_mode_t3", 32'(ex_alu_mode_o), 1);

        // Back-to-back writes; the last one wins
        drive(1, 0, 0, 0, 1, 32'h0000_1111); tick();
        drive(1, 0, 0, 0, 1, 32'h0000_2222);
        check("b2b_busy_t1", 32'(policy_busy_o), 1);
        check("b2b_bubble_t1", 32'(ex_valid_o), 0);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        check("b2b_busy_t2", 32'(policy_busy_o), 1);
        check("b2b_bubble_t2", 32'(ex_valid_o), 0);
        check("b2b_rdata", csr_rdata_o, 32'h0000_2222);
        tick();
        check("b2b_bubble_t3", 32'(ex_valid_o), 0);
        tick();
        check("b2b_valid", 32'(ex_valid_o), 1);
        check("b2b_mode", 32'(ex_alu_mode_o), 2);

        // Stall holds the slot for three cycles, then flush wins over stall
        for (int i = 0; i < 3; i++) begin
            drive(1, 5, 1, 0, 0, 0);
            check("stall_ready", 32'(id_ready_o), 0);
            tick();
            check("stall_valid", 32'(ex_valid_o), 1);
            check("stall_mode", 32'(ex_alu_mode_o), 2);
        end
        drive(1, 5, 1, 1, 0, 0); tick();
        check("flush_valid", 32'(ex_valid_o), 0);
        check("flush_mode", 32'(ex_alu_mode_o), 0);

        // Stall during settle does not delay the new policy
        drive(0, 0, 0, 0, 1, 32'h0000_FFFF); tick();
        drive(1, 0, 1, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0);
        check("stset_busy", 32'(policy_busy_o), 0);
        tick();
        check("stset_mode", 32'(ex_alu_mode_o), 3);

        // Reset mid-update discards the write
        drive(0, 0, 0, 0, 1, 32'h0000_0000); tick();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0); tick();
        rst = 1'b0;
        drive(1, 0, 0, 0, 0, 0);
        check("rstmid_rdata", csr_rdata_o, 32'h0000_0EAA);
        check("rstmid_busy", 32'(policy_busy_o), 0);
        check("rstmid_ready", 32'(id_ready_o), 1);
        tick();
        check("rstmid_mode", 32'(ex_alu_mode_o), 2);
        check("rstmid_valid", 32'(ex_valid_o), 1);

        drive(0, 0, 0, 0, 0, 0); tick(); tick();
        started = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
